// File: rtl/netlist_packer_pkg.sv
// Shared definitions for the netlist load interface: field width, header
// word indices, gate-word layout, packer state encoding and the gate-word
// packing function also used by the store-side decoder.
package netlist_packer_pkg;

  localparam int P     = 13;
  localparam int IN0_W = 27 - P;

  localparam int HDR_INIT    = 0;
  localparam int HDR_IN      = 1;
  localparam int HDR_SZ      = 2;
  localparam int HDR_GATE    = 3;
  localparam int N_CKT_PARAM = 4;

  localparam int GW_ISOUT_LSB = 0;
  localparam int GW_LOGIC_LSB = 1;
  localparam int GW_IN1_LSB   = 5;
  localparam int GW_IN0_LSB   = 5 + P;

  typedef enum logic [2:0] {IDLE, FILL, LAUNCH, HDR, STREAM, DONE} state_e;

  // Gate word: {in0, in1, logic, is_out}, fields already truncated by caller.
  function automatic logic [31:0] pack_gate(input logic [IN0_W-1:0] in0,
                                            input logic [P-1:0]     in1,
                                            input logic [3:0]       lg,
                                            input logic             is_out);
    return (32'(in0)    << GW_IN0_LSB)
         | (32'(in1)    << GW_IN1_LSB)
         | (32'(lg)     << GW_LOGIC_LSB)
         | (32'(is_out) << GW_ISOUT_LSB);
  endfunction

  // Header word: two P-bit counts, each zero-extended into a 16-bit half.
  function automatic logic [31:0] pack_hdr(input logic [P-1:0] hi,
                                           input logic [P-1:0] lo);
    return {{(16-P){1'b0}}, hi, {(16-P){1'b0}}, lo};
  endfunction

endpackage

// File: rtl/netlist_packer_word_buf.sv
// Gate-word buffer: simple dual-port 32 x DEPTH RAM with one-cycle registered
// read. Read data holds when no read is issued, which the burst prefetch
// relies on while the header words go out.
module netlist_word_buf #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/netlist_packer.sv
// Netlist packer: transmit side of the netlist load interface. Latches circuit
// parameters, packs and buffers gate descriptors, then on go emits a start
// strobe and an unthrottled burst: W0, W1, W2, W3, W3 (pad), then N gate words.
// Optional build macro NETLIST_CHECK_EN enables descriptor/config range checks
// and the sticky error output; without it error is tied low.
module netlist_packer
  import netlist_packer_pkg::*;
#(
  parameter int S     = 14,
  parameter int DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic [P-1:0]        cfg_init_a,
  input  logic [P-1:0]        cfg_init_b,
  input  logic [P-1:0]        cfg_in_a,
  input  logic [P-1:0]        cfg_in_b,
  input  logic [P-1:0]        cfg_dff,
  input  logic [P-1:0]        cfg_out,
  input  logic [P-1:0]        cfg_gates,
  input  logic [P-1:0]        cfg_xor,
  input  logic                gate_valid,
  output logic                gate_ready,
  input  logic signed [S-1:0] gate_in0,
  input  logic signed [S-1:0] gate_in1,
  input  logic [3:0]          gate_logic,
  input  logic                gate_is_out,
  input  logic                go,
  output logic                start,
  output logic [31:0]         netlist_out,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q;
  logic [P:0]    n_q;
  logic [P:0]    cnt_q;
  logic [1:0]    hdr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          start_q;
  logic          done_q;
  logic [31:0]   out_q;
  logic [31:0]   hw_q [N_CKT_PARAM];

  logic [P:0]    n_d;
  logic [31:0]   gate_word_d;
  logic [31:0]   rd_data;
  logic          xfer;
  logic          wr_en;
  logic          rd_en;
  logic          gate_ok;
  logic          cfg_ok;

  assign n_d         = {1'b0, cfg_dff} + {1'b0, cfg_gates};
  assign gate_word_d = pack_gate(gate_in0[IN0_W-1:0], gate_in1[P-1:0],
                                 gate_logic, gate_is_out);
  assign gate_ready  = (state_q == FILL) && (cnt_q < n_q);
  assign xfer        = gate_valid && gate_ready;
  assign wr_en       = xfer && gate_ok;
  // Reads: buf[0] in LAUNCH, buf[1] on the pad cycle, then one per STREAM cycle,
  // so each gate word is already in the read register when it is needed.
  assign rd_en       = (state_q == LAUNCH)
                     || ((state_q == HDR) && (hdr_q == 2'd3) && (n_q != '0))
                     || (state_q == STREAM);

`ifdef NETLIST_CHECK_EN
  localparam int TW = P + 3;
  logic [TW-1:0] total_q;
  logic [TW-1:0] total_d;
  logic [31:0]   in0_u;
  logic [31:0]   in1_u;
  logic [31:0]   tot_u;
  logic          error_q;

  assign total_d = TW'(cfg_init_a) + TW'(cfg_init_b) + TW'(cfg_in_a)
                 + TW'(cfg_in_b) + TW'(cfg_dff) + TW'(cfg_gates);
  assign in0_u   = 32'($unsigned(gate_in0));
  assign in1_u   = 32'($unsigned(gate_in1));
  assign tot_u   = 32'(total_q);
  assign gate_ok = !gate_in0[S-1] && !gate_in1[S-1]
                && (in0_u < tot_u) && (in1_u < tot_u)
                && ((in0_u >> IN0_W) == 32'd0);
  assign cfg_ok  = (32'(n_d) <= 32'(DEPTH));

  // Wire total captured with the parameters, used to bound gate indices.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && cfg_valid) total_q <= total_d;
  end

  // Sticky error: set on a rejected descriptor or an oversize configuration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else if ((xfer && !gate_ok) || ((state_q == IDLE) && cfg_valid && !cfg_ok)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_in1_msb;

  assign gate_ok        = 1'b1;
  assign cfg_ok         = 1'b1;
  assign error          = 1'b0;
  assign unused_in1_msb = ^gate_in1[S-1:P];
`endif

  // Header words captured when the parameters are accepted.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && cfg_valid) begin
      hw_q[HDR_INIT] <= pack_hdr(cfg_init_a, cfg_init_b);
      hw_q[HDR_IN]   <= pack_hdr(cfg_in_a, cfg_in_b);
      hw_q[HDR_SZ]   <= pack_hdr(cfg_dff, cfg_out);
      hw_q[HDR_GATE] <= pack_hdr(cfg_xor, cfg_gates);
    end
  end

  netlist_word_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (gate_word_d),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Control FSM: fill bookkeeping, burst sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      hdr_q    <= '0;
      rd_ptr_q <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          out_q <= '0;
          if (cfg_valid && cfg_ok) begin
            n_q     <= n_d;
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (wr_en) cnt_q <= cnt_q + 1'b1;
          if ((cnt_q == n_q) && go) begin
            state_q  <= LAUNCH;
            start_q  <= 1'b1;
            out_q    <= hw_q[HDR_INIT];
            rd_ptr_q <= '0;
          end
        end
        LAUNCH: begin
          out_q    <= hw_q[HDR_IN];
          rd_ptr_q <= rd_ptr_q + 1'b1;
          hdr_q    <= '0;
          cnt_q    <= '0;
          state_q  <= HDR;
        end
        HDR: begin
          hdr_q <= hdr_q + 1'b1;
          case (hdr_q)
            2'd0:    out_q <= hw_q[HDR_SZ];
            2'd1:    out_q <= hw_q[HDR_GATE];
            2'd2:    out_q <= hw_q[HDR_GATE];
            default: begin
              if (n_q == '0) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                out_q    <= '0;
                rd_ptr_q <= '0;
              end else begin
                state_q  <= STREAM;
                out_q    <= rd_data;
                rd_ptr_q <= rd_ptr_q + 1'b1;
              end
            end
          endcase
        end
        STREAM: begin
          cnt_q <= cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == n_q) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            out_q    <= '0;
            rd_ptr_q <= '0;
          end else begin
            out_q    <= rd_data;
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        DONE: begin
          out_q   <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start       = start_q;
  assign done        = done_q;
  assign netlist_out = out_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_netlist_packer.sv
// Testbench for netlist_packer: table of gate descriptors with hand-packed
// words, plus directed sequences for N=0, early go, full-depth fill with
// random valid gaps, and reset during a burst. Honors NETLIST_CHECK_EN.
module tb_netlist_packer;
  import netlist_packer_pkg::*;

`ifdef NETLIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 4096;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic [P-1:0]       cfg_init_a, cfg_init_b, cfg_in_a, cfg_in_b;
  logic [P-1:0]       cfg_dff, cfg_out, cfg_gates, cfg_xor;
  logic               gate_valid;
  logic               gate_ready;
  logic signed [13:0] gate_in0, gate_in1;
  logic [3:0]         gate_logic;
  logic               gate_is_out;
  logic               go;
  logic               start;
  logic [31:0]        netlist_out;
  logic               busy, done, error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic signed [13:0] in0;
    logic signed [13:0] in1;
    logic [3:0]         lg;
    logic               io;
    logic               bad;
    logic [31:0]        exp;
  } vec_t;
  vec_t tbl[7];

  netlist_packer #(.S(14), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
    .cfg_init_a(cfg_init_a), .cfg_init_b(cfg_init_b),
    .cfg_in_a(cfg_in_a), .cfg_in_b(cfg_in_b),
    .cfg_dff(cfg_dff), .cfg_out(cfg_out),
    .cfg_gates(cfg_gates), .cfg_xor(cfg_xor),
    .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_in0(gate_in0), .gate_in1(gate_in1),
    .gate_logic(gate_logic), .gate_is_out(gate_is_out),
    .go(go), .start(start), .netlist_out(netlist_out),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  function automatic logic [31:0] hw(input int a, input int b);
    return ((32'(a) & 32'h1FFF) << 16) | (32'(b) & 32'h1FFF);
  endfunction

  function automatic logic [31:0] model_gate(input int in0, input int in1, input int lg, input int io);
    return ((32'(in0) & 32'h3FFF) << 18) | ((32'(in1) & 32'h1FFF) << 5)
         | ((32'(lg) & 32'hF) << 1) | (32'(io) & 32'h1);
  endfunction

  task automatic push_hdr(input int ia, input int ib, input int na, input int nb,
                          input int dff, input int out, input int g, input int x);
    exp_q.push_back(hw(ia, ib));
    exp_q.push_back(hw(na, nb));
    exp_q.push_back(hw(dff, out));
    exp_q.push_back(hw(x, g));
    exp_q.push_back(hw(x, g));
  endtask

  task automatic send_cfg(input int ia, input int ib, input int na, input int nb,
                          input int dff, input int out, input int g, input int x);
    cfg_init_a = P'(ia); cfg_init_b = P'(ib);
    cfg_in_a   = P'(na); cfg_in_b   = P'(nb);
    cfg_dff    = P'(dff); cfg_out   = P'(out);
    cfg_gates  = P'(g);  cfg_xor    = P'(x);
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic send_gate(input logic signed [13:0] in0, input logic signed [13:0] in1,
                           input logic [3:0] lg, input logic io);
    int t = 0;
    gate_in0 = in0; gate_in1 = in1; gate_logic = lg; gate_is_out = io;
    gate_valid = 1'b1;
    while (!gate_ready && t < 50) begin step(); t++; end
    if (!gate_ready) begin
      total_cnt++;
      $display("FAIL gate_ready_timeout: ready low for %0d cycles, expected 1", t);
    end else begin
      step();
    end
    gate_valid = 1'b0;
  endtask

  // Called at the cycle where start is expected high; walks N+6 cycles.
  task automatic check_burst(input int n, input string nm);
    int starts = 0;
    int dones  = 0;
    for (int i = 0; i < n + 6; i++) begin
      if (i > 0) step();
      starts += int'(start);
      dones  += int'(done);
      if (i < n + 5) begin
        chk($sformatf("%s_w%0d", nm, i), netlist_out, exp_q[i]);
      end else begin
        chk($sformatf("%s_done_word", nm), netlist_out, 32'h0);
        chk1($sformatf("%s_done_pulse", nm), done, 1'b1);
      end
    end
    chk($sformatf("%s_start_count", nm), starts, 1);
    chk($sformatf("%s_done_count", nm), dones, 1);
    step();
    chk1($sformatf("%s_idle_busy", nm), busy, 1'b0);
    chk($sformatf("%s_idle_out", nm), netlist_out, 32'h0);
    exp_q.delete();
  endtask

  task automatic launch(input int n, input string nm);
    int t = 0;
    go = 1'b1;
    do begin step(); t++; end while (!start && t < 20);
    go = 1'b0;
    if (!start) begin
      total_cnt++;
      $display("FAIL %s_start_timeout: start low after %0d cycles, expected 1", nm, t);
      exp_q.delete();
    end else begin
      check_burst(n, nm);
    end
  endtask

  initial begin
    int n_tbl;
    rst = 1'b0; cfg_valid = 1'b0; gate_valid = 1'b0; go = 1'b0;
    cfg_init_a = '0; cfg_init_b = '0; cfg_in_a = '0; cfg_in_b = '0;
    cfg_dff = '0; cfg_out = '0; cfg_gates = '0; cfg_xor = '0;
    gate_in0 = '0; gate_in1 = '0; gate_logic = '0; gate_is_out = 1'b0;
    step(); step();

    // Reset state
    chk1("rst_start", start, 1'b0);
    chk("rst_out", netlist_out, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_ready", gate_ready, 1'b0);
    rst = 1'b1;
    step();

    // Basic burst with hand-packed words
    send_cfg(2, 2, 3, 1, 0, 1, 2, 1);
    chk1("t1_busy_fill", busy, 1'b1);
    send_gate(14'sd0, 14'sd1, 4'h8, 1'b0);
    send_gate(14'sd5, 14'sd4, 4'h6, 1'b1);
    exp_q = '{32'h00020002, 32'h00030001, 32'h00000001, 32'h00010002,
              32'h00010002, 32'h00000030, 32'h0014008D};
    launch(2, "t1");

    // Descriptor table
    tbl[0] = '{14'sd0,    14'sd1,     4'h8, 1'b0, 1'b0, 32'h00000030};
    tbl[1] = '{14'sd5,    14'sd4,     4'h6, 1'b1, 1'b0, 32'h0014008D};
    tbl[2] = '{14'sd8191, 14'sd8191,  4'hF, 1'b1, 1'b1, 32'h7FFFFFFF};
    tbl[3] = '{-14'sd1,   -14'sd1,    4'h0, 1'b0, 1'b1, 32'hFFFFFFE0};
    tbl[4] = '{14'sd5461, 14'sd2730,  4'hA, 1'b0, 1'b0, 32'h55555554};
    tbl[5] = '{14'sd3,    14'sh2000,  4'h1, 1'b0, 1'b1, 32'h000C0002};
    tbl[6] = '{14'sd0,    14'sd0,     4'h0, 1'b1, 1'b0, 32'h00000001};
    n_tbl = 0;
    foreach (tbl[k]) if (!CHK || !tbl[k].bad) n_tbl++;
    send_cfg(8000, 1, 2, 3, 1, 5, n_tbl - 1, 2);
    push_hdr(8000, 1, 2, 3, 1, 5, n_tbl - 1, 2);
    foreach (tbl[k]) begin
      send_gate(tbl[k].in0, tbl[k].in1, tbl[k].lg, tbl[k].io);
      if (!CHK || !tbl[k].bad) exp_q.push_back(tbl[k].exp);
    end
    launch(n_tbl, "tbl");
    chk1("tbl_error", error, CHK);

    // N = 0: ready never asserted, header-only burst
    send_cfg(1, 0, 0, 0, 0, 7, 0, 3);
    gate_valid = 1'b1;
    chk1("t2_ready0", gate_ready, 1'b0);
    step();
    chk1("t2_ready1", gate_ready, 1'b0);
    gate_valid = 1'b0;
    exp_q = '{32'h00010000, 32'h00000000, 32'h00000007, 32'h00030000, 32'h00030000};
    launch(0, "t2");

    // go held high before fill completes
    send_cfg(3, 0, 0, 2, 1, 1, 1, 0);
    go = 1'b1;
    step();
    chk1("t3_early_go0", start, 1'b0);
    send_gate(14'sd1, 14'sd2, 4'hE, 1'b0);
    chk1("t3_early_go1", start, 1'b0);
    step();
    chk1("t3_early_go2", start, 1'b0);
    send_gate(14'sd4, 14'sd0, 4'h7, 1'b1);
    chk1("t3_after_last", start, 1'b0);
    step();
    chk1("t3_start", start, 1'b1);
    go = 1'b0;
    exp_q = '{32'h00030000, 32'h00000002, 32'h00010001, 32'h00000001,
              32'h00000001, 32'h0004005C, 32'h0010000F};
    check_burst(2, "t3");

    // Reset in the middle of the gate-word stream
    send_cfg(4, 4, 0, 0, 0, 0, 3, 0);
    send_gate(14'sd1, 14'sd1, 4'h1, 1'b0);
    send_gate(14'sd2, 14'sd2, 4'h2, 1'b0);
    send_gate(14'sd3, 14'sd3, 4'h3, 1'b0);
    go = 1'b1;
    step();
    go = 1'b0;
    chk1("t5_start", start, 1'b1);
    repeat (6) step();
    chk1("t5_streaming", busy, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk1("t5_rst_start", start, 1'b0);
    chk("t5_rst_out", netlist_out, 32'h0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_done", done, 1'b0);
    chk1("t5_rst_error", error, 1'b0);
    send_cfg(0, 5, 1, 0, 1, 1, 0, 0);
    chk1("t5_new_cfg_busy", busy, 1'b1);
    send_gate(14'sd2, 14'sd3, 4'h9, 1'b1);
    exp_q = '{32'h00000005, 32'h00010000, 32'h00010001, 32'h00000000,
              32'h00000000, 32'h00080073};
    launch(1, "t5");

`ifdef NETLIST_CHECK_EN
    // Oversize configuration is refused and flags error
    send_cfg(10, 0, 0, 0, 4000, 0, 200, 0);
    chk1("t6_cfg_reject_busy", busy, 1'b0);
    chk1("t6_cfg_reject_error", error, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk1("t6_error_cleared", error, 1'b0);
`endif

    // Full-depth fill with random valid gaps, streamed back in order
    send_cfg(8000, 0, 0, 0, 96, 0, 4000, 1);
    push_hdr(8000, 0, 0, 0, 96, 0, 4000, 1);
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_gate(14'(i), 14'(i ^ 32'h155), 4'(i), 1'(i));
      exp_q.push_back(model_gate(i, i ^ 32'h155, i, i));
    end
    launch(DEPTH, "t4");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
